// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake bundle for the decode stage.
// The slave side is the decode stage; the master side drives it.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_imm_type;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc,
    input  flush, out_ready,
    output in_ready, out_valid,
    output out_instr, out_pc, out_imm,
    output out_imm_type, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc,
    output flush, out_ready,
    input  in_ready, out_valid,
    input  out_instr, out_pc, out_imm,
    input  out_imm_type, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered decode stage: opcode classify, imm32 generation,
// and a 2-entry skid buffer with flush toward execute.
module decode_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOIMM_VAL = 32'h0
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      ty;
    logic            ill;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q;

  logic [6:0] op;
  logic [2:0] ty;
  logic       ill;
  entry_t     inc;
  logic       acc;
  logic       emit;

  // Unknown types yield all-ones; caller masks that case.
  function automatic logic [31:0] imm32(
    input logic [24:0] in,
    input logic [2:0]  t
  );
    logic [31:0] w;
    w = {in, 7'b0};
    unique case (t)
      3'd0: imm32 = {{20{w[31]}}, w[31:20]};
      3'd1: imm32 = {{20{w[31]}}, w[7],
                     w[30:25], w[11:8], 1'b0};
      3'd2: imm32 = {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3: imm32 = {w[31:12], 12'b0};
      3'd4: imm32 = {{12{w[31]}}, w[19:12],
                     w[20], w[30:21], 1'b0};
      default: imm32 = 32'hFFFF_FFFF;
    endcase
  endfunction

  assign op = bus.in_instr[6:0];

  always_comb begin
    ty  = 3'd7;
    ill = 1'b0;
    unique case (1'b1)
      (op == 7'b0000011) || (op == 7'b0010011) ||
      (op == 7'b1100111) || (op == 7'b1110011):
        ty = 3'd0;
      (op == 7'b0100011): ty = 3'd2;
      (op == 7'b1100011): ty = 3'd1;
      (op == 7'b0110111) || (op == 7'b0010111):
        ty = 3'd3;
      (op == 7'b1101111): ty = 3'd4;
      (op == 7'b0110011): ty = 3'd7;
      default:            ill = 1'b1;
    endcase
  end

  always_comb begin
    inc.instr = bus.in_instr;
    inc.pc    = bus.in_pc;
    inc.ty    = ty;
    inc.ill   = ill;
    inc.imm   = (ty == 3'd7) ? NOIMM_VAL
              : imm32(bus.in_instr[31:7], ty);
  end

  assign acc  = bus.in_valid && in_ready_q;
  assign emit = (state_q != EMPTY) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (acc) begin
          head_d  = inc;
          state_d = ONE;
        end
        ONE: begin
          if (acc && !emit) begin
            skid_d  = inc;
            state_d = TWO;
          end else if (!acc && emit) begin
            state_d = EMPTY;
          end else if (acc && emit) begin
            head_d = inc;
          end
        end
        TWO: if (emit) begin
          head_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = (state_q != EMPTY);
  assign bus.out_instr    = head_q.instr;
  assign bus.out_pc       = head_q.pc;
  assign bus.out_imm      = head_q.imm;
  assign bus.out_imm_type = head_q.ty;
  assign bus.out_illegal  = head_q.ill;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode values,
// skid buffering, flush and asynchronous reset.
module tb_decode_stage;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  decode_stage_if #(.XLEN(32)) bus ();

  decode_stage #(
    .XLEN(32),
    .NOIMM_VAL(32'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [31:0] ins,
                       input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc    = pc;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #3;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: valid=%b ready=%b want 0 0",
               bus.out_valid, bus.in_ready);
    end
    n_chk++;
    if (bus.out_imm !== 32'h0 || bus.out_imm_type !== 3'd0 ||
        bus.out_illegal !== 1'b0 || bus.out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: imm=%h ty=%0d ill=%b pc=%h want 0",
               bus.out_imm, bus.out_imm_type,
               bus.out_illegal, bus.out_pc);
    end
    #9 rst_n = 1'b1;
    step();
    n_chk++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b want 1",
               bus.in_ready);
    end
  endtask

  task automatic test_addi();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 32'h100);
    step();
    drive(1'b0, 32'h0, 32'h0);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'hFFFFFFFF ||
        bus.out_imm_type !== 3'd0 || bus.out_pc !== 32'h100 ||
        bus.out_illegal !== 1'b0 ||
        bus.out_instr !== 32'hFFF00093) begin
      n_fail++;
      $display("FAIL addi: v=%b imm=%h ty=%0d pc=%h ill=%b",
               bus.out_valid, bus.out_imm, bus.out_imm_type,
               bus.out_pc, bus.out_illegal);
    end
    step();
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_drain: out_valid=%b want 0",
               bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4];
    logic [31:0] imm [4];
    logic [2:0]  ty  [4];
    ins = '{32'h123452B7, 32'hFFDFF06F, 32'h00000463, 32'hFE202E23};
    imm = '{32'h12345000, 32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFFC};
    ty  = '{3'd3, 3'd4, 3'd1, 3'd2};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ins[i], 32'h10 + 32'(4 * i));
      step();
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_imm !== imm[i] ||
          bus.out_imm_type !== ty[i] ||
          bus.out_pc !== 32'h10 + 32'(4 * i) ||
          bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b[%0d]: v=%b imm=%h ty=%0d pc=%h want imm=%h ty=%0d",
                 i, bus.out_valid, bus.out_imm, bus.out_imm_type,
                 bus.out_pc, imm[i], ty[i]);
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'h200);
    step();
    drive(1'b1, 32'h123452B7, 32'h204);
    step();
    n_chk++;
    if (bus.in_ready !== 1'b0 || bus.out_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL stall_full: ready=%b pc=%h want 0 200",
               bus.in_ready, bus.out_pc);
    end
    drive(1'b1, 32'hFFDFF06F, 32'h208);
    step();
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 ||
        bus.out_imm !== 32'hFFFFFFFF || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: v=%b pc=%h imm=%h rdy=%b",
               bus.out_valid, bus.out_pc, bus.out_imm, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    step();
    n_chk++;
    if (bus.out_pc !== 32'h204 || bus.out_imm !== 32'h12345000 ||
        bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_emit1: pc=%h imm=%h rdy=%b want 204",
               bus.out_pc, bus.out_imm, bus.in_ready);
    end
    step();
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h208 ||
        bus.out_imm !== 32'hFFFFFFFC) begin
      n_fail++;
      $display("FAIL stall_emit2: v=%b pc=%h imm=%h want 208",
               bus.out_valid, bus.out_pc, bus.out_imm);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_drain: out_valid=%b want 0",
               bus.out_valid);
    end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0000007F, 32'h300);
    step();
    n_chk++;
    if (bus.out_illegal !== 1'b1 || bus.out_imm_type !== 3'd7 ||
        bus.out_imm !== 32'h0) begin
      n_fail++;
      $display("FAIL illegal_7f: ill=%b ty=%0d imm=%h want 1 7 0",
               bus.out_illegal, bus.out_imm_type, bus.out_imm);
    end
    drive(1'b1, 32'h002081B3, 32'h304);
    step();
    n_chk++;
    if (bus.out_illegal !== 1'b0 || bus.out_imm_type !== 3'd7 ||
        bus.out_imm !== 32'h0 || bus.out_pc !== 32'h304) begin
      n_fail++;
      $display("FAIL rtype_add: ill=%b ty=%0d imm=%h want 0 7 0",
               bus.out_illegal, bus.out_imm_type, bus.out_imm);
    end
    drive(1'b1, 32'hFFF00090, 32'h308);
    step();
    n_chk++;
    if (bus.out_illegal !== 1'b1 || bus.out_imm_type !== 3'd7 ||
        bus.out_imm !== 32'h0) begin
      n_fail++;
      $display("FAIL illegal_lowbits: ill=%b ty=%0d imm=%h want 1 7 0",
               bus.out_illegal, bus.out_imm_type, bus.out_imm);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_flush();
    int seen;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'h500);
    step();
    drive(1'b1, 32'h123452B7, 32'h504);
    step();
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hFFDFF06F, 32'h508);
    step();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: v=%b rdy=%b want 0 1",
               bus.out_valid, bus.in_ready);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.out_valid === 1'b1) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL flush_quiet: %0d valid cycles want 0", seen);
    end
    drive(1'b1, 32'h00000463, 32'h50C);
    step();
    drive(1'b0, 32'h0, 32'h0);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h50C ||
        bus.out_imm !== 32'h8) begin
      n_fail++;
      $display("FAIL flush_after: v=%b pc=%h imm=%h want 50c 8",
               bus.out_valid, bus.out_pc, bus.out_imm);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'h600);
    step();
    drive(1'b1, 32'h123452B7, 32'h604);
    step();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0 ||
        bus.out_imm !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: v=%b rdy=%b pc=%h ins=%h imm=%h",
               bus.out_valid, bus.in_ready, bus.out_pc,
               bus.out_instr, bus.out_imm);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    #2 rst_n = 1'b1;
    step();
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_rel: rdy=%b v=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hFE202E23, 32'h700);
    step();
    drive(1'b0, 32'h0, 32'h0);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h700 ||
        bus.out_imm !== 32'hFFFFFFFC || bus.out_imm_type !== 3'd2) begin
      n_fail++;
      $display("FAIL reset_mid_new: v=%b pc=%h imm=%h ty=%0d",
               bus.out_valid, bus.out_pc, bus.out_imm,
               bus.out_imm_type);
    end
    step();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
